// File: rtl/physics_integrator_nch_if.sv
// Control, force and status bundle for the multi-ball integrator.
interface physics_integrator_nch_if #(
    parameter int NCH = 4,
    parameter int FW  = 24
);
    logic                step_i;
    logic                reinit_i;
    logic                home_i;
    logic [NCH*FW-1:0]   force_x_i;
    logic [NCH*FW-1:0]   force_y_i;
    logic [NCH*6-1:0]    mass_g_i;
    logic [2:0]          fric_l_i;
    logic                wall_mode_i;
    logic                busy_o;
    logic                step_done_o;
    logic [NCH*16-1:0]   pos_x_o;
    logic [NCH*16-1:0]   pos_y_o;
    logic [NCH-1:0]      goal_o;
    logic                all_goal_o;

    modport master (
        output step_i, reinit_i, home_i, force_x_i, force_y_i, mass_g_i, fric_l_i, wall_mode_i,
        input  busy_o, step_done_o, pos_x_o, pos_y_o, goal_o, all_goal_o
    );
    modport slave (
        input  step_i, reinit_i, home_i, force_x_i, force_y_i, mass_g_i, fric_l_i, wall_mode_i,
        output busy_o, step_done_o, pos_x_o, pos_y_o, goal_o, all_goal_o
    );
endinterface

// File: rtl/physics_integrator_nch.sv
// NCH-ball 2D integrator sharing one datapath: one ball per cycle, a whole
// step per step_i pulse, with friction, clamp/reflect walls and goal dwell.
module physics_integrator_nch #(
    parameter int          NCH           = 4,
    parameter int          FRAC          = 12,
    parameter int          FW            = 24,
    parameter int          PLANE_SIZE_MM = 300,
    parameter int          GOAL_RAD_MM   = 5,
    parameter int          DWELL         = 8,
    parameter logic [31:0] LFSR_SEED     = 32'hACE12468
) (
    input logic                     clk,
    input logic                     rst,
    physics_integrator_nch_if.slave bus
);
    localparam int              HALF_MM   = PLANE_SIZE_MM / 2;
    localparam int              LIM       = HALF_MM << FRAC;
    localparam int              CW        = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0]   LAST      = CW'(NCH - 1);
    localparam int              PW        = FW + 21;
    localparam logic [31:0]     GOAL_R2   = 32'(GOAL_RAD_MM * GOAL_RAD_MM);
    localparam logic [7:0]      DWELL_MAX = 8'(DWELL);

    typedef logic signed [31:0] s32_t;
    typedef enum logic [1:0] {S_INIT, S_IDLE, S_CALC, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     k_q, k_d;
    logic [31:0]       lfsr_q, lfsr_d;
    s32_t              px_q [NCH], px_d [NCH], py_q [NCH], py_d [NCH];
    s32_t              vx_q [NCH], vx_d [NCH], vy_q [NCH], vy_d [NCH];
    logic [7:0]        dw_q [NCH], dw_d [NCH];
    logic [NCH-1:0]    goal_q, goal_d;
    logic [NCH*16-1:0] posx_q, posx_d, posy_q, posy_d;
    logic [NCH*FW-1:0] fx_q, fx_d, fy_q, fy_d;
    logic [NCH*6-1:0]  m_q, m_d;
    logic [2:0]        fric_q, fric_d;
    logic              mode_q, mode_d;
    logic [20:0]       invm_k;
    logic [63:0]       ux, uy;

    // Q20 reciprocal of the mass in grams, mass clamped to 1..30.
    function automatic logic [20:0] invm_lut(input logic [5:0] m);
        logic [20:0] r;
        r = 21'd1048575;
        for (int i = 2; i <= 30; i++)
            if (m == 6'(i)) r = 21'(1048576 / i);
        if (m > 6'd30) r = 21'(1048576 / 30);
        return r;
    endfunction

    // Random start position in [-HALF/2, HALF/2) mm, as Q FRAC.
    function automatic s32_t init_pos(input logic [9:0] r);
        int mm;
        mm = int'({22'd0, r}) % HALF_MM - HALF_MM / 2;
        return s32_t'(mm <<< FRAC);
    endfunction

    // One axis update: {new position, new velocity}. Position uses the old velocity.
    function automatic logic [63:0] axis_upd(input s32_t p, input s32_t v, input logic [FW-1:0] f,
                                             input logic [20:0] invm, input logic [2:0] fric,
                                             input logic mode);
        logic signed [PW-1:0] prod;
        s32_t a, fr, vn, pn;
        logic hit;
        prod = PW'($signed(f)) * $signed({{FW{1'b0}}, invm});
        a    = s32_t'(prod >>> 20);
        fr   = (fric == 3'd0) ? 32'sd0 : (v >>> fric);
        vn   = v + a - fr;
        if (vn > LIM) vn = LIM;
        else if (vn < -LIM) vn = -LIM;
        pn  = p + v;
        hit = 1'b0;
        if (pn > LIM) begin
            pn  = LIM;
            hit = 1'b1;
        end else if (pn < -LIM) begin
            pn  = -LIM;
            hit = 1'b1;
        end
        if (hit) vn = mode ? -vn : 32'sd0;
        return {pn, vn};
    endfunction

    // Dwell counter: saturating count of consecutive in-goal steps.
    function automatic logic [7:0] dwell_next(input logic [7:0] d, input s32_t x, input s32_t y);
        s32_t xm, ym;
        logic [31:0] r2;
        logic [7:0] n;
        xm = x >>> FRAC;
        ym = y >>> FRAC;
        r2 = 32'(xm * xm) + 32'(ym * ym);
        if (r2 > GOAL_R2) n = 8'd0;
        else n = (d >= DWELL_MAX) ? DWELL_MAX : d + 8'd1;
        return n;
    endfunction

    // State and datapath registers; reset lands in INIT with cleared balls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_INIT;
            k_q     <= '0;
            lfsr_q  <= LFSR_SEED;
            px_q    <= '{default: '0};
            py_q    <= '{default: '0};
            vx_q    <= '{default: '0};
            vy_q    <= '{default: '0};
            dw_q    <= '{default: '0};
            goal_q  <= '0;
            posx_q  <= '0;
            posy_q  <= '0;
            fx_q    <= '0;
            fy_q    <= '0;
            m_q     <= '0;
            fric_q  <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            lfsr_q  <= lfsr_d;
            px_q    <= px_d;
            py_q    <= py_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            dw_q    <= dw_d;
            goal_q  <= goal_d;
            posx_q  <= posx_d;
            posy_q  <= posy_d;
            fx_q    <= fx_d;
            fy_q    <= fy_d;
            m_q     <= m_d;
            fric_q  <= fric_d;
            mode_q  <= mode_d;
        end
    end

    // Next state: home beats reinit beats step; other states ignore inputs.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT: if (k_q == LAST) state_d = S_IDLE;
            S_IDLE: begin
                if (bus.home_i)        state_d = S_IDLE;
                else if (bus.reinit_i) state_d = S_INIT;
                else if (bus.step_i)   state_d = S_CALC;
            end
            S_CALC: if (k_q == LAST) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_INIT;
        endcase
    end

    // Per-state datapath: placement, home, snapshot, channel update, goal dwell.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? 32'h80200003 : 32'h0);
        k_d    = k_q;
        px_d   = px_q;
        py_d   = py_q;
        vx_d   = vx_q;
        vy_d   = vy_q;
        dw_d   = dw_q;
        goal_d = goal_q;
        fx_d   = fx_q;
        fy_d   = fy_q;
        m_d    = m_q;
        fric_d = fric_q;
        mode_d = mode_q;
        invm_k = invm_lut(m_q[k_q*6 +: 6]);
        ux = axis_upd(px_q[k_q], vx_q[k_q], fx_q[k_q*FW +: FW], invm_k, fric_q, mode_q);
        uy = axis_upd(py_q[k_q], vy_q[k_q], fy_q[k_q*FW +: FW], invm_k, fric_q, mode_q);
        case (state_q)
            S_INIT: begin
                px_d[k_q] = init_pos(lfsr_q[9:0]);
                py_d[k_q] = init_pos(lfsr_q[25:16]);
                vx_d[k_q] = '0;
                vy_d[k_q] = '0;
                dw_d[k_q] = '0;
                k_d       = (k_q == LAST) ? '0 : k_q + 1'b1;
            end
            S_IDLE: begin
                k_d = '0;
                if (bus.home_i) begin
                    px_d   = '{default: '0};
                    py_d   = '{default: '0};
                    vx_d   = '{default: '0};
                    vy_d   = '{default: '0};
                    dw_d   = '{default: '0};
                    goal_d = '0;
                end else if (bus.reinit_i) begin
                    goal_d = '0;
                end else if (bus.step_i) begin
                    fx_d   = bus.force_x_i;
                    fy_d   = bus.force_y_i;
                    m_d    = bus.mass_g_i;
                    fric_d = bus.fric_l_i;
                    mode_d = bus.wall_mode_i;
                end
            end
            S_CALC: begin
                px_d[k_q] = s32_t'(ux[63:32]);
                vx_d[k_q] = s32_t'(ux[31:0]);
                py_d[k_q] = s32_t'(uy[63:32]);
                vy_d[k_q] = s32_t'(uy[31:0]);
                k_d       = (k_q == LAST) ? '0 : k_q + 1'b1;
            end
            S_DONE: begin
                for (int c = 0; c < NCH; c++) begin
                    dw_d[c]   = dwell_next(dw_q[c], px_q[c], py_q[c]);
                    goal_d[c] = (dw_d[c] >= DWELL_MAX);
                end
            end
            default: ;
        endcase
        for (int c = 0; c < NCH; c++) begin
            posx_d[c*16 +: 16] = 16'(px_q[c] >>> FRAC);
            posy_d[c*16 +: 16] = 16'(py_q[c] >>> FRAC);
        end
    end

    // Status outputs; busy is held low while reset is asserted.
    assign bus.busy_o      = (state_q != S_IDLE) && !rst;
    assign bus.step_done_o = (state_q == S_DONE);
    assign bus.pos_x_o     = posx_q;
    assign bus.pos_y_o     = posy_q;
    assign bus.goal_o      = goal_q;
    assign bus.all_goal_o  = &goal_q;
endmodule

// File: tb/tb_physics_integrator_nch.sv
// Scoreboard bench: stimulus pushes model-predicted step results, a monitor
// pops and compares them when step_done_o appears.
module tb_physics_integrator_nch;
    localparam int NCH = 4, FW = 24, FRAC = 12, HALF = 150, LIM = HALF << FRAC;
    localparam int DWELL = 8, GR2 = 25;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int cyc = 0, checks = 0, failures = 0;

    typedef struct {
        int done_cyc;
        bit chk;
        logic [NCH*16-1:0] px, py;
        logic [NCH-1:0] goal;
    } exp_t;
    exp_t sb[$];

    longint mpx[NCH], mpy[NCH], mvx[NCH], mvy[NCH];
    int mdw[NCH];
    bit known = 0;
    int sfx[NCH], sfy[NCH], sm[NCH];
    int sfric = 0, smode = 0;

    physics_integrator_nch_if #(.NCH(NCH), .FW(FW)) bus ();

    physics_integrator_nch #(.NCH(NCH), .FRAC(FRAC), .FW(FW), .PLANE_SIZE_MM(300),
                             .GOAL_RAD_MM(5), .DWELL(DWELL), .LFSR_SEED(32'hACE12468))
        dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    function automatic longint invm(input int m);
        int mm;
        mm = (m == 0) ? 1 : (m > 30 ? 30 : m);
        return (mm == 1) ? 64'd1048575 : 64'd1048576 / mm;
    endfunction

    // Reference physics for one axis, straight from the rules in plain integers.
    task automatic axis(inout longint p, inout longint v, input longint f, input int m);
        longint a, vn, pn;
        bit hit;
        a  = (f * invm(m)) >>> 20;
        vn = v + a - ((sfric == 0) ? 0 : (v >>> sfric));
        if (vn > LIM) vn = LIM;
        if (vn < -LIM) vn = -LIM;
        pn  = p + v;
        hit = (pn > LIM) || (pn < -LIM);
        if (pn > LIM) pn = LIM;
        if (pn < -LIM) pn = -LIM;
        if (hit) vn = (smode != 0) ? -vn : 0;
        p = pn;
        v = vn;
    endtask

    task automatic model_step(input int done_cyc);
        exp_t e;
        longint p, v, x, y;
        for (int k = 0; k < NCH; k++) begin
            p = mpx[k]; v = mvx[k]; axis(p, v, longint'(sfx[k]), sm[k]); mpx[k] = p; mvx[k] = v;
            p = mpy[k]; v = mvy[k]; axis(p, v, longint'(sfy[k]), sm[k]); mpy[k] = p; mvy[k] = v;
        end
        for (int k = 0; k < NCH; k++) begin
            x = mpx[k] >>> FRAC;
            y = mpy[k] >>> FRAC;
            if (x * x + y * y <= GR2) mdw[k] = (mdw[k] < DWELL) ? mdw[k] + 1 : DWELL;
            else mdw[k] = 0;
            e.goal[k] = (mdw[k] >= DWELL);
            e.px[k*16 +: 16] = 16'(x);
            e.py[k*16 +: 16] = 16'(y);
        end
        e.done_cyc = done_cyc;
        e.chk = known;
        sb.push_back(e);
    endtask

    task automatic drive_inputs();
        for (int k = 0; k < NCH; k++) begin
            bus.force_x_i[k*FW +: FW] = sfx[k][FW-1:0];
            bus.force_y_i[k*FW +: FW] = sfy[k][FW-1:0];
            bus.mass_g_i[k*6 +: 6]    = sm[k][5:0];
        end
        bus.fric_l_i    = sfric[2:0];
        bus.wall_mode_i = smode[0];
    endtask

    task automatic zero_forces(input int mass);
        for (int k = 0; k < NCH; k++) begin
            sfx[k] = 0; sfy[k] = 0; sm[k] = mass;
        end
        sfric = 0; smode = 0;
    endtask

    task automatic check_range();
        for (int k = 0; k < NCH; k++) begin
            chk("init_range_x", ($signed(bus.pos_x_o[k*16 +: 16]) >= -75) && ($signed(bus.pos_x_o[k*16 +: 16]) <= 74), 1);
            chk("init_range_y", ($signed(bus.pos_y_o[k*16 +: 16]) >= -75) && ($signed(bus.pos_y_o[k*16 +: 16]) <= 74), 1);
        end
    endtask

    task automatic release_init();
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < NCH; i++) begin
            chk("init_busy_high", bus.busy_o, 1);
            @(negedge clk);
        end
        chk("init_busy_low", bus.busy_o, 0);
        @(negedge clk);
        check_range();
        known = 0;
    endtask

    task automatic do_home();
        @(negedge clk);
        bus.home_i = 1'b1;
        @(negedge clk);
        bus.home_i = 1'b0;
        @(negedge clk);
        chk("home_pos_x", bus.pos_x_o, 0);
        chk("home_pos_y", bus.pos_y_o, 0);
        chk("home_goal", bus.goal_o, 0);
        for (int k = 0; k < NCH; k++) begin
            mpx[k] = 0; mpy[k] = 0; mvx[k] = 0; mvy[k] = 0; mdw[k] = 0;
        end
        known = 1;
    endtask

    // extra != 0 pulses step_i again in the second CALC cycle; it must be ignored.
    task automatic do_step(input int extra);
        int c;
        @(negedge clk);
        drive_inputs();
        bus.step_i = 1'b1;
        c = cyc;
        model_step(c + NCH + 1);
        @(negedge clk);
        bus.step_i = 1'b0;
        chk("busy_after_accept", bus.busy_o, 1);
        if (extra != 0) begin
            @(negedge clk);
            bus.step_i = 1'b1;
            @(negedge clk);
            bus.step_i = 1'b0;
            repeat (NCH - 1) @(negedge clk);
        end else begin
            repeat (NCH + 1) @(negedge clk);
        end
        chk("busy_low_after_step", bus.busy_o, 0);
    endtask

    task automatic do_reinit(input bit with_step);
        @(negedge clk);
        bus.reinit_i = 1'b1;
        bus.step_i   = with_step;
        @(negedge clk);
        bus.reinit_i = 1'b0;
        bus.step_i   = 1'b0;
        chk("reinit_busy", bus.busy_o, 1);
        chk("goal_drop_in_init", bus.goal_o, 0);
        repeat (NCH) @(negedge clk);
        chk("reinit_busy_low", bus.busy_o, 0);
        @(negedge clk);
        check_range();
        known = 0;
    endtask

    task automatic rand_forces(input bit big);
        for (int k = 0; k < NCH; k++) begin
            sfx[k] = big ? (int'($urandom) >>> 8) : (int'($urandom) >>> 15);
            sfy[k] = big ? (int'($urandom) >>> 8) : (int'($urandom) >>> 15);
            sm[k]  = int'($urandom_range(0, 63));
        end
        sfric = int'($urandom_range(0, 7));
        smode = int'($urandom_range(0, 1));
    endtask

    // Monitor: every step_done_o must match a queued step, then the outputs one cycle later.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.step_done_o) begin
                chk("step_done_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("step_done_latency", cyc, e.done_cyc);
                    @(negedge clk);
                    if (e.chk) begin
                        chk("pos_x", bus.pos_x_o, e.px);
                        chk("pos_y", bus.pos_y_o, e.py);
                        chk("goal", bus.goal_o, e.goal);
                        chk("all_goal", bus.all_goal_o, &e.goal);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.step_i = 1'b0; bus.reinit_i = 1'b0; bus.home_i = 1'b0;
        zero_forces(1);
        drive_inputs();
        #12;
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_done", bus.step_done_o, 0);
        chk("rst_pos_x", bus.pos_x_o, 0);
        chk("rst_pos_y", bus.pos_y_o, 0);
        chk("rst_goal", bus.goal_o, 0);
        chk("rst_all_goal", bus.all_goal_o, 0);
        repeat (2) @(negedge clk);
        release_init();
        do_step(0);

        // Constant force on ball 0: pos 0, 0, then 2 mm.
        do_home();
        zero_forces(1);
        sfx[0] = 4096;
        do_step(0); chk("ch0_px_step1", $signed(bus.pos_x_o[15:0]), 0);
        do_step(0); chk("ch0_px_step2", $signed(bus.pos_x_o[15:0]), 0);
        do_step(0); chk("ch0_px_step3", $signed(bus.pos_x_o[15:0]), 2);

        // Full force into the wall, clamp mode.
        do_home();
        zero_forces(1);
        sfx[1] = 32'h7FFFFF;
        for (int s = 1; s <= 5; s++) begin
            do_step(0);
            if (s >= 3) chk("clamp_wall_150", $signed(bus.pos_x_o[31:16]), 150);
        end

        // Same in reflect mode: ball bounces back to 0 mm.
        do_home();
        smode = 1;
        for (int s = 1; s <= 4; s++) do_step(0);
        chk("reflect_back", $signed(bus.pos_x_o[31:16]), 0);

        // Resting at the origin qualifies the goal after DWELL steps.
        do_home();
        zero_forces(1);
        for (int s = 1; s <= DWELL; s++) begin
            do_step(0);
            chk("dwell_goal", bus.goal_o, (s >= DWELL) ? 4'hF : 4'h0);
        end
        chk("dwell_all_goal", bus.all_goal_o, 1);
        do_reinit(1'b0);

        // Ignored inputs: step during CALC, reinit together with step.
        do_home();
        rand_forces(1'b0);
        do_step(1);
        do_reinit(1'b1);

        // Reset in the second CALC cycle aborts the step.
        do_home();
        rand_forces(1'b0);
        @(negedge clk);
        drive_inputs();
        bus.step_i = 1'b1;
        @(negedge clk);
        bus.step_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", bus.busy_o, 0);
        chk("abort_done", bus.step_done_o, 0);
        chk("abort_pos_x", bus.pos_x_o, 0);
        chk("abort_pos_y", bus.pos_y_o, 0);
        chk("abort_goal", bus.goal_o, 0);
        repeat (3) @(negedge clk);
        release_init();
        zero_forces(1);
        do_step(0);

        // Randomized steps against the model.
        do_home();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) do_home();
            rand_forces($urandom_range(0, 1) == 1);
            do_step(0);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/physics_integrator_nch.md
Name: physics_integrator_nch

Overview:
Parametrised successor of the 2D rolling-ball integrator. It integrates NCH independent balls by time-multiplexing one shared datapath: one channel is updated per cycle, and a whole step is triggered by a pulse. It adds runtime friction and wall modes (clamp or reflect), a centre-home command, and a goal-dwell qualifier per ball. It sits between the force generator and the score/display logic.

Parameters:
NCH, 4, number of balls (1..16)
FRAC, 12, Q fractional bits of position/velocity
FW, 24, signed force width per axis (Q FRAC)
PLANE_SIZE_MM, 300, square side; HALF_MM = PLANE_SIZE_MM/2
GOAL_RAD_MM, 5, goal circle radius around origin
DWELL, 8, consecutive in-goal steps before goal_o asserts (1..255)
LFSR_SEED, 32'hACE12468, nonzero reset seed of internal 32-bit LFSR

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
step_i  in  1  request one integration step of all channels
reinit_i  in  1  random re-placement request
home_i  in  1  place all balls at origin
force_x_i  in  NCH*FW  signed per-channel X force, channel k at [k*FW +: FW]
force_y_i  in  NCH*FW  signed per-channel Y force
mass_g_i  in  NCH*6  per-channel mass in grams
fric_l_i  in  3  friction shift; 0 = frictionless
wall_mode_i  in  1  0 clamp, 1 reflect
busy_o  out  1  FSM not IDLE
step_done_o  out  1  one-cycle pulse at end of step
pos_x_o  out  NCH*16  signed mm X per channel
pos_y_o  out  NCH*16  signed mm Y per channel
goal_o  out  NCH  per-channel dwell-qualified goal flag
all_goal_o  out  1  AND of goal_o

Behaviour:
- Reset (async, rst=1): all outputs 0; positions, velocities and dwell counters 0; LFSR=LFSR_SEED; FSM=INIT. Reset mid-step aborts the step immediately, with no partial pulse.
- FSM states: INIT, IDLE, CALC, DONE.
- LFSR advances every cycle in every state.
- INIT: one channel per cycle, k=0..NCH-1, NCH cycles, busy_o=1.
  - px = mm(rnd[9:0] % HALF_MM − HALF_MM/2); py uses rnd[25:16]. Range is [-75,74] mm at default.
  - v=0 and dwell=0 for every channel. Then go to IDLE.
- IDLE, priority home_i > reinit_i > step_i:
  - home_i: all p=v=0, dwell=0 in one cycle; stay IDLE.
  - reinit_i: go to INIT.
  - step_i: snapshot force_x_i, force_y_i, mass_g_i, fric_l_i and wall_mode_i, then go to CALC.
- Inputs in any state other than IDLE are ignored, not queued.
- CALC: channel k is updated in cycle k (NCH cycles). Per channel, using snapshot values:
  - m: 0 is treated as 1, >30 as 30. invm is the Q20 LUT (1→1048575, 2→524288, …, 30→34952).
  - a = (F·invm) >>> 20, with a 45-bit signed product.
  - v' = v + a − (fric==0 ? 0 : v>>>fric). Saturate v' to ±(HALF_MM<<FRAC).
  - p' = p + v, using the old v.
  - Wall at lim = HALF_MM<<FRAC: if p' > lim, p' = lim; if p' < −lim, p' = −lim. On an axis that hit:
    - mode 0: v' = 0
    - mode 1: v' = −v'
- The pos_x_o/pos_y_o slice for channel k updates in the cycle after its write. Value is p>>>FRAC (floor).
- DONE (1 cycle): step_done_o=1. For each channel, in_goal = x²+y² ≤ GOAL_RAD_MM², 32-bit unsigned compare.
  - in_goal true: dwell increments, saturating at DWELL. Otherwise dwell=0.
  - goal_o[k] = (dwell ≥ DWELL), registered.
  - Then go to IDLE.
- Latency: step_i accepted at cycle T → busy_o=1 from T+1, step_done_o at T+NCH+1, busy_o=0 at T+NCH+2. A step_i in that same cycle is accepted.
- After reset release: busy_o=1 from the first cycle. It drops after NCH INIT cycles.

Test Plan:
- Release reset, zero forces → busy_o high 4 cycles, every pos in [-75,74]. Step → step_done_o exactly 5 cycles after accept, positions unchanged.
- home_i, ch0 F_x=4096, mass 1, fric 0 → after step1 pos_x unchanged with v=4095. After step2 internal px=4095, pos_x_o=0. After step3 px=12285+… (2·4095+4095), pos_x_o=2.
- home_i, ch1 F_x=+0x7FFFFF, mass 1, mode 0 → pos_x_o saturates at 150 and v_x reads 0 after the hit. Repeat with mode 1 → v_x negative and pos_x_o decreases on the next step.
- home_i, zero forces, 8 steps → goal_o=0 through step 7, goal_o=4'hF and all_goal_o=1 after step 8. Then reinit_i → goal_o drops in the INIT cycle.
- step_i pulsed again during CALC, and reinit_i+step_i together in IDLE → the second step is ignored, and INIT wins with no step_done_o.
- rst asserted in the 2nd CALC cycle → outputs 0 immediately. After release, INIT runs and the first step_i gives a normal 5-cycle step.
